// File: rtl/boom_display.sv
// Two-digit seven-segment driver for the comparator: shows the latched number, or blinks
// both digits after a boom. Define BOOM_DISPLAY_COUNT_EN to add the saturating boom_cnt output.
module boom_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int BOOM_BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] code,
  input  logic       boom_in,
  input  logic       code_valid,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       boom_led,
  output logic       busy
`ifdef BOOM_DISPLAY_COUNT_EN
  ,
  output logic [7:0] boom_cnt
`endif
);

  localparam int RW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PHASES = 2 * BOOM_BLINKS;
  localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST   = PW'(PHASES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    BOOM = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    code_q;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    an_q;
  logic [BW-1:0] blink_cnt;
  logic [PW-1:0] phase_cnt;
  logic          busy_q;

  logic          accept;
  logic          is_boom;
  logic          blink_wrap;
  logic          last_phase;
  logic [1:0]    tens;
  logic [3:0]    units;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign accept     = code_valid && !busy_q;
  assign is_boom    = boom_in || (code == 5'h1F);
  assign blink_wrap = (blink_cnt == BLINK_LAST);
  assign last_phase = (phase_cnt == PHASE_LAST);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, SHOW: if (accept) state_d = is_boom ? BOOM : SHOW;
      BOOM:       if (blink_wrap && last_phase) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      code_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == BOOM);
      if (accept) code_q <= code;
    end
  end

  // Digit mux runs in every state so the refresh cadence never glitches on state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      an_q        <= 2'b10;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      an_q        <= ~an_q;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Counters idle at zero outside BOOM, so every entry starts a fresh on-phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_cnt <= '0;
    end else if (state_q != BOOM) begin
      blink_cnt <= '0;
      phase_cnt <= '0;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      phase_cnt <= last_phase ? '0 : phase_cnt + 1'b1;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    tens  = 2'd0;
    units = code_q[3:0];
    if (code_q >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(code_q - 5'd30);
    end else if (code_q >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(code_q - 5'd20);
    end else if (code_q >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(code_q - 5'd10);
    end
  end

  always_comb begin
    seg      = 7'h7F;
    boom_led = 1'b0;
    case (state_q)
      SHOW: begin
        if (!an_q[0])          seg = digit_seg(units);
        else if (tens != 2'd0) seg = digit_seg({2'b00, tens});
      end
      BOOM: begin
        if (!phase_cnt[0]) begin
          seg      = 7'h00;
          boom_led = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign an   = an_q;
  assign busy = busy_q;

`ifdef BOOM_DISPLAY_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      boom_cnt <= 8'd0;
    else if (state_q != BOOM && state_d == BOOM && boom_cnt != 8'hFF)
      boom_cnt <= boom_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_boom_display.sv
// Directed self-checking bench for boom_display with REFRESH_DIV=4, BLINK_DIV=8, BOOM_BLINKS=2.
// Define BOOM_DISPLAY_COUNT_EN to also exercise boom_cnt.
module tb_boom_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] code;
  logic       boom_in;
  logic       code_valid;
  logic [6:0] seg;
  logic [1:0] an;
  logic       boom_led;
  logic       busy;
`ifdef BOOM_DISPLAY_COUNT_EN
  logic [7:0] boom_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int edges;

  boom_display #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (8),
    .BOOM_BLINKS(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code      (code),
    .boom_in   (boom_in),
    .code_valid(code_valid),
    .seg       (seg),
    .an        (an),
    .boom_led  (boom_led),
    .busy      (busy)
`ifdef BOOM_DISPLAY_COUNT_EN
    ,
    .boom_cnt  (boom_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; the digit mux flips every 4 of them.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic logic [1:0] exp_an(input int e);
    return (((e / 4) % 2) == 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [4:0] c, input logic b);
    @(negedge clk);
    code       = c;
    boom_in    = b;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    boom_in    = 1'b0;
  endtask

  task automatic show_check(input string tag, input int value);
    logic [1:0] a;
    logic [6:0] s;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = exp_an(edges);
      if (a == 2'b10)           s = enc(value % 10);
      else if (value / 10 == 0) s = 7'h7F;
      else                      s = enc(value / 10);
      check({tag, "_an"}, 32'(an), 32'(a));
      check({tag, "_seg"}, 32'(seg), 32'(s));
      check({tag, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  // Walks the 32 BOOM cycles; optionally offers a code at cycle drop_at and on the exit cycle.
  task automatic boom_check(input string tag, input int drop_at, input logic exit_drop);
    logic on;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      code_valid = 1'b0;
      on = (((i / 8) % 2) == 0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_led"}, 32'(boom_led), 32'(on));
      check({tag, "_seg"}, 32'(seg), on ? 32'h00 : 32'h7F);
      if (i == drop_at) begin
        code       = 5'd5;
        code_valid = 1'b1;
      end
      if (i == 31 && exit_drop) begin
        code       = 5'd9;
        code_valid = 1'b1;
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      code_valid = 1'b0;
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_led"}, 32'(boom_led), 32'd0);
      check({tag, "_idle_seg"}, 32'(seg), 32'h7F);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    code       = 5'd0;
    boom_in    = 1'b0;
    code_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'h2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_led", 32'(boom_led), 32'd0);
`ifdef BOOM_DISPLAY_COUNT_EN
    check("rst_cnt", 32'(boom_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rel_an", 32'(an), 32'h2);

    // Blank display with the digit mux free-running.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("idle_an", 32'(an), 32'(exp_an(edges)));
      check("idle_seg", 32'(seg), 32'h7F);
      check("idle_busy", 32'(busy), 32'd0);
    end

    strobe(5'd23, 1'b0);
    show_check("show23", 23);
    strobe(5'd7, 1'b0);
    show_check("show7", 7);
    strobe(5'd0, 1'b0);
    show_check("show0", 0);
    strobe(5'd30, 1'b0);
    show_check("show30", 30);
    strobe(5'd10, 1'b0);
    show_check("show10", 10);

    strobe(5'd31, 1'b0);
    boom_check("boom31", -1, 1'b0);
`ifdef BOOM_DISPLAY_COUNT_EN
    check("cnt_one", 32'(boom_cnt), 32'd1);
`endif

    strobe(5'd23, 1'b0);
    show_check("show23b", 23);
    strobe(5'd12, 1'b1);
    boom_check("boomflag", 10, 1'b1);

    // Asynchronous reset in the middle of an on-phase.
    strobe(5'd31, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_led", 32'(boom_led), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_an", 32'(an), 32'h2);
    check("arst_led", 32'(boom_led), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_led", 32'(boom_led), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
      check("post_seg", 32'(seg), 32'h7F);
    end

`ifdef BOOM_DISPLAY_COUNT_EN
    check("cnt_cleared", 32'(boom_cnt), 32'd0);
    for (int i = 0; i < 300; i++) begin
      strobe(5'd31, 1'b0);
      repeat (34) @(posedge clk);
    end
    @(negedge clk);
    check("cnt_sat", 32'(boom_cnt), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
